morse_key_decoder: RTL and testbench

- Receive-side counterpart to the Morse tune player.
- Samples a single hand-key or keyer line and times its marks and spaces in Morse units.
- Emits the same 2-bit symbol stream the player consumes, and assembles each letter's dot/dash pattern for downstream lookup.
- Sits between the off-chip key pin and any character lookup or display logic.

---
 rtl/morse_key_decoder.sv | 178 +++++++++++++++++
 tb/tb_morse_key_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_decoder.sv
// Morse key receiver: times marks and spaces on a key line in Morse units,
// emits the 2-bit symbol stream and assembles each letter's dot/dash pattern.
module morse_key_decoder #(
    parameter int UNIT_TICKS = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_in,
    output logic [1:0] sym,
    output logic       sym_valid,
    output logic [5:0] letter_pattern,
    output logic [2:0] letter_len,
    output logic       letter_valid,
    output logic       err,
    output logic       key_active
);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, STUCK} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DASH_MIN  = CNT_W'(2 * UNIT_TICKS);
    localparam logic [CNT_W-1:0] LGAP_CNT  = CNT_W'(2 * UNIT_TICKS);
    localparam logic [CNT_W-1:0] WGAP_CNT  = CNT_W'(5 * UNIT_TICKS);
    localparam logic [CNT_W-1:0] STUCK_CNT = CNT_W'(7 * UNIT_TICKS);

    localparam logic [1:0] SYM_LGAP = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;
    localparam logic [1:0] SYM_WGAP = 2'b11;

    state_t           state_q, state_d;
    logic             key_m_q, key_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [5:0]       acc_pat_q, acc_pat_d;
    logic [2:0]       acc_len_q, acc_len_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       sym_q, sym_d;
    logic             sym_valid_q, sym_valid_d;
    logic [5:0]       pat_q, pat_d;
    logic [2:0]       len_q, len_d;
    logic             letter_valid_q, letter_valid_d;
    logic             err_q, err_d;
    logic             push_elem, elem_bit, close_letter;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_pat_d      = acc_pat_q;
        acc_len_d      = acc_len_q;
        ovf_d          = ovf_q;
        sym_d          = sym_q;
        pat_d          = pat_q;
        len_d          = len_q;
        sym_valid_d    = 1'b0;
        letter_valid_d = 1'b0;
        err_d          = 1'b0;
        push_elem      = 1'b0;
        elem_bit       = 1'b0;
        close_letter   = 1'b0;
        cnt_inc        = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

        unique case (state_q)
            IDLE: begin
                if (key_s_q) begin
                    state_d = MARK;
                    cnt_d   = CNT_ONE;
                end
            end
            MARK: begin
                if (key_s_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == STUCK_CNT) begin
                        err_d   = 1'b1;
                        ovf_d   = 1'b1;
                        state_d = STUCK;
                    end
                end else begin
                    push_elem   = 1'b1;
                    elem_bit    = (cnt_q >= DASH_MIN);
                    sym_d       = elem_bit ? SYM_DASH : SYM_DOT;
                    sym_valid_d = 1'b1;
                    state_d     = SPACE;
                    cnt_d       = CNT_ONE;
                end
            end
            SPACE: begin
                // A key rise wins over a gap threshold reached the same cycle
                if (key_s_q) begin
                    state_d = MARK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == LGAP_CNT) begin
                        close_letter = 1'b1;
                        sym_d        = SYM_LGAP;
                        sym_valid_d  = 1'b1;
                    end
                    if (cnt_inc == WGAP_CNT) begin
                        sym_d       = SYM_WGAP;
                        sym_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            STUCK: begin
                if (!key_s_q) begin
                    state_d = SPACE;
                    cnt_d   = CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push_elem) begin
            if (acc_len_q < 3'd6) begin
                acc_pat_d = {acc_pat_q[4:0], elem_bit};
                acc_len_d = acc_len_q + 3'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (close_letter) begin
            if (ovf_q) begin
                err_d = 1'b1;
            end else if (acc_len_q != 3'd0) begin
                letter_valid_d = 1'b1;
                pat_d          = acc_pat_q;
                len_d          = acc_len_q;
            end
            acc_pat_d = '0;
            acc_len_d = '0;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            key_m_q        <= 1'b0;
            key_s_q        <= 1'b0;
            cnt_q          <= '0;
            acc_pat_q      <= '0;
            acc_len_q      <= '0;
            ovf_q          <= 1'b0;
            sym_q          <= '0;
            sym_valid_q    <= 1'b0;
            pat_q          <= '0;
            len_q          <= '0;
            letter_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_m_q        <= key_in;
            key_s_q        <= key_m_q;
            cnt_q          <= cnt_d;
            acc_pat_q      <= acc_pat_d;
            acc_len_q      <= acc_len_d;
            ovf_q          <= ovf_d;
            sym_q          <= sym_d;
            sym_valid_q    <= sym_valid_d;
            pat_q          <= pat_d;
            len_q          <= len_d;
            letter_valid_q <= letter_valid_d;
            err_q          <= err_d;
        end
    end

    assign sym            = sym_q;
    assign sym_valid      = sym_valid_q;
    assign letter_pattern = pat_q;
    assign letter_len     = len_q;
    assign letter_valid   = letter_valid_q;
    assign err            = err_q;
    assign key_active     = key_s_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: run-length reference model checked every
// cycle, plus literal expectations at the key timing points.
module tb_morse_key_decoder;

    localparam int U = 4;

    logic       clk;
    logic       reset_n;
    logic       key_in;
    logic [1:0] sym;
    logic       sym_valid;
    logic [5:0] letter_pattern;
    logic [2:0] letter_len;
    logic       letter_valid;
    logic       err;
    logic       key_active;

    morse_key_decoder #(.UNIT_TICKS(U), .CNT_W(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .key_in         (key_in),
        .sym            (sym),
        .sym_valid      (sym_valid),
        .letter_pattern (letter_pattern),
        .letter_len     (letter_len),
        .letter_valid   (letter_valid),
        .err            (err),
        .key_active     (key_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    endtask

    // Reference model: key_s is key_in delayed two samples; marks and spaces
    // are measured as run lengths of that delayed level.
    logic       m_km = 1'b0;
    logic       m_ks = 1'b0;
    logic       ks_old;
    int         mark_run = 0;
    int         low_run = 0;
    bit         spacing = 0;
    bit         stuck = 0;
    bit         m_ovf = 0;
    bit         elems[$];
    logic [1:0] e_sym = '0;
    logic       e_sv = 1'b0;
    logic       e_lv = 1'b0;
    logic       e_err = 1'b0;
    logic [5:0] e_pat = '0;
    logic [2:0] e_len = '0;

    task automatic model_gap();
        int p;
        e_sym = 2'b00;
        e_sv  = 1'b1;
        if (m_ovf) begin
            e_err = 1'b1;
        end else if (elems.size() > 0) begin
            p = 0;
            foreach (elems[i]) p = p * 2 + int'(elems[i]);
            e_lv  = 1'b1;
            e_pat = 6'(p);
            e_len = 3'(elems.size());
        end
        elems.delete();
        m_ovf = 0;
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_km = 0; m_ks = 0; mark_run = 0; low_run = 0;
            spacing = 0; stuck = 0; m_ovf = 0; elems.delete();
            e_sym = 0; e_sv = 0; e_lv = 0; e_err = 0; e_pat = 0; e_len = 0;
        end else begin
            ks_old = m_ks;
            m_ks = m_km;
            m_km = key_in;
            e_sv = 0; e_lv = 0; e_err = 0;
            if (ks_old) begin
                mark_run++;
                low_run = 0;
                spacing = 0;
                if (mark_run == 7 * U && !stuck) begin
                    e_err = 1; stuck = 1; m_ovf = 1;
                end
            end else if (mark_run > 0) begin
                if (!stuck) begin
                    e_sym = (mark_run < 2 * U) ? 2'b01 : 2'b10;
                    e_sv  = 1;
                    if (elems.size() < 6) elems.push_back(mark_run >= 2 * U);
                    else m_ovf = 1;
                end
                mark_run = 0; stuck = 0; spacing = 1; low_run = 1;
            end else if (spacing) begin
                low_run++;
                if (low_run == 2 * U) model_gap();
                if (low_run == 5 * U) begin
                    e_sym = 2'b11; e_sv = 1; spacing = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("sym", int'(sym), int'(e_sym));
        chk("sym_valid", int'(sym_valid), int'(e_sv));
        chk("letter_pattern", int'(letter_pattern), int'(e_pat));
        chk("letter_len", int'(letter_len), int'(e_len));
        chk("letter_valid", int'(letter_valid), int'(e_lv));
        chk("err", int'(err), int'(e_err));
        chk("key_active", int'(key_active), int'(m_ks));
    end

    task automatic lit(input string name, input int act, input int mdl, input int want);
        chk(name, act, want);
        chk({name, "_model"}, mdl, want);
    endtask

    task automatic key(input logic v, input int n);
        key_in = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b1;
        key_in  = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        lit("reset_out", int'({sym, sym_valid, letter_valid, err, key_active}),
            int'({e_sym, e_sv, e_lv, e_err, m_ks}), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // single dot, then letter gap and word gap
        key(1'b1, 4);
        key_in = 1'b0;
        repeat (3) @(negedge clk);
        lit("t1_dot", int'({sym_valid, sym}), int'({e_sv, e_sym}), 3'b101);
        repeat (7) @(negedge clk);
        lit("t1_lgap", int'({letter_valid, sym_valid, sym}),
            int'({e_lv, e_sv, e_sym}), 4'b1100);
        lit("t1_lgap_len", int'(letter_len), int'(e_len), 1);
        repeat (12) @(negedge clk);
        lit("t1_wgap", int'({sym_valid, sym}), int'({e_sv, e_sym}), 3'b111);
        repeat (8) @(negedge clk);

        // letter A
        key(1'b1, 4);
        key(1'b0, 4);
        key(1'b1, 12);
        key_in = 1'b0;
        repeat (3) @(negedge clk);
        lit("a_dash", int'({sym_valid, sym}), int'({e_sv, e_sym}), 3'b110);
        repeat (7) @(negedge clk);
        lit("a_gap", int'({letter_valid, sym_valid, sym}),
            int'({e_lv, e_sv, e_sym}), 4'b1100);
        lit("a_pat", int'(letter_pattern), int'(e_pat), 1);
        lit("a_len", int'(letter_len), int'(e_len), 2);

        // stuck key
        key_in = 1'b1;
        repeat (30) @(negedge clk);
        lit("stuck_err", int'({err, sym_valid}), int'({e_err, e_sv}), 2'b10);
        repeat (10) @(negedge clk);
        key_in = 1'b0;
        repeat (10) @(negedge clk);
        lit("stuck_gap", int'({err, letter_valid, sym_valid, sym}),
            int'({e_err, e_lv, e_sv, e_sym}), 5'b10100);

        // seven dots overflow the letter
        for (int i = 0; i < 7; i++) begin
            key(1'b1, 4);
            if (i < 6) key(1'b0, 4);
        end
        key_in = 1'b0;
        repeat (10) @(negedge clk);
        lit("ovf_gap", int'({err, letter_valid, sym_valid, sym}),
            int'({e_err, e_lv, e_sv, e_sym}), 5'b10100);
        key(1'b1, 12);
        key_in = 1'b0;
        repeat (10) @(negedge clk);
        lit("rec_gap", int'({err, letter_valid, sym_valid, sym}),
            int'({e_err, e_lv, e_sv, e_sym}), 5'b01100);
        lit("rec_pat", int'(letter_pattern), int'(e_pat), 1);
        lit("rec_len", int'(letter_len), int'(e_len), 1);

        // key rise on the letter-gap cycle suppresses the gap
        key(1'b1, 4);
        key(1'b0, 7);
        key_in = 1'b1;
        repeat (3) @(negedge clk);
        lit("rise_nogap", int'(sym_valid), int'(e_sv), 0);
        repeat (9) @(negedge clk);
        key_in = 1'b0;
        repeat (10) @(negedge clk);
        lit("rise_gap", int'({letter_valid, sym_valid, sym}),
            int'({e_lv, e_sv, e_sym}), 4'b1100);
        lit("rise_pat", int'(letter_pattern), int'(e_pat), 1);
        lit("rise_len", int'(letter_len), int'(e_len), 2);

        // async reset mid-mark
        key(1'b1, 12);
        key(1'b0, 4);
        key_in = 1'b1;
        repeat (10) @(negedge clk);
        lit("pre_rst", int'({key_active, sym}), int'({m_ks, e_sym}), 3'b110);
        #1 reset_n = 1'b0;
        #1;
        lit("rst_async", int'({sym, sym_valid, letter_pattern, letter_len,
                               letter_valid, err, key_active}),
            int'({e_sym, e_sv, e_pat, e_len, e_lv, e_err, m_ks}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        key_in = 1'b0;
        repeat (3) @(negedge clk);
        lit("post_rst_dot", int'({sym_valid, sym}), int'({e_sv, e_sym}), 3'b101);
        repeat (7) @(negedge clk);
        lit("post_rst_gap", int'({letter_valid, letter_len}),
            int'({e_lv, e_len}), 4'b1001);
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
